// File: rtl/dmux16_stream.sv
// Registered 1-to-WAYS stream demultiplexer with a one-entry holding register per channel.
// Optional per-channel delivered-word counters are enabled by defining DMUX16_COUNT_EN.
module dmux16_stream #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned WAYS  = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WAYS*WIDTH-1:0] out_data,
  output logic [WAYS-1:0]       out_valid,
  input  logic [WAYS-1:0]       out_ready,
`ifdef DMUX16_COUNT_EN
  output logic [WAYS*16-1:0]    out_count,
`endif
  output logic                  sel_err
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q [WAYS];
  state_e           state_d [WAYS];
  logic [WIDTH-1:0] hold_q  [WAYS];
  logic [WIDTH-1:0] hold_d  [WAYS];
  logic             sel_err_q, sel_err_d;
  logic             sel_in_range;
  logic             acc;
  logic [WAYS-1:0]  wr;
  logic [WAYS-1:0]  drain;

  assign sel_in_range = int'(in_sel) < int'(WAYS);

  // Out-of-range selects are always accepted so the producer never stalls on a bad word.
  always_comb begin
    in_ready = 1'b1;
    for (int k = 0; k < int'(WAYS); k++) begin
      if (int'(in_sel) == k) begin
        in_ready = !out_valid[k] | out_ready[k];
      end
    end
  end

  assign acc = in_valid & in_ready;

  always_comb begin
    for (int k = 0; k < int'(WAYS); k++) begin
      wr[k]    = acc & sel_in_range & (int'(in_sel) == k);
      drain[k] = out_valid[k] & out_ready[k];
    end
  end

  always_comb begin
    for (int k = 0; k < int'(WAYS); k++) begin
      state_d[k] = state_q[k];
      hold_d[k]  = hold_q[k];
      if (wr[k]) begin
        hold_d[k] = in_data;
      end
      unique case (state_q[k])
        StEmpty: if (wr[k]) state_d[k] = StFull;
        StFull:  if (drain[k] && !wr[k]) state_d[k] = StEmpty;
        default: state_d[k] = StEmpty;
      endcase
    end
    sel_err_d = acc & !sel_in_range;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(WAYS); k++) begin
        state_q[k] <= StEmpty;
        hold_q[k]  <= '0;
      end
      sel_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < int'(WAYS); k++) begin
        state_q[k] <= state_d[k];
        hold_q[k]  <= hold_d[k];
      end
      sel_err_q <= sel_err_d;
    end
  end

  always_comb begin
    for (int k = 0; k < int'(WAYS); k++) begin
      out_valid[k]                 = (state_q[k] == StFull);
      out_data[k*WIDTH +: WIDTH] = hold_q[k];
    end
  end

  assign sel_err = sel_err_q;

`ifdef DMUX16_COUNT_EN
  logic [15:0] cnt_q [WAYS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(WAYS); k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(WAYS); k++) begin
        if (drain[k]) begin
          cnt_q[k] <= cnt_q[k] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < int'(WAYS); k++) begin
      out_count[k*16 +: 16] = cnt_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_dmux16_stream.sv
// Directed self-checking bench for dmux16_stream: a 4-way instance for the main behaviour
// and a 3-way instance for the out-of-range select path.
module tb_dmux16_stream;

  logic        clk = 1'b0;
  logic        reset;

  // 4-way instance
  logic [15:0] a_in_data;
  logic [1:0]  a_in_sel;
  logic        a_in_valid;
  logic        a_in_ready;
  logic [63:0] a_out_data;
  logic [3:0]  a_out_valid;
  logic [3:0]  a_out_ready;
  logic        a_sel_err;
`ifdef DMUX16_COUNT_EN
  logic [63:0] a_out_count;
  logic [47:0] b_out_count;
`endif

  // 3-way instance
  logic [15:0] b_in_data;
  logic [1:0]  b_in_sel;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [47:0] b_out_data;
  logic [2:0]  b_out_valid;
  logic [2:0]  b_out_ready;
  logic        b_sel_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmux16_stream #(.WIDTH(16), .WAYS(4), .SEL_W(2)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_data   (a_in_data),
    .in_sel    (a_in_sel),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
`ifdef DMUX16_COUNT_EN
    .out_count (a_out_count),
`endif
    .sel_err   (a_sel_err)
  );

  dmux16_stream #(.WIDTH(16), .WAYS(3), .SEL_W(2)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_data   (b_in_data),
    .in_sel    (b_in_sel),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
`ifdef DMUX16_COUNT_EN
    .out_count (b_out_count),
`endif
    .sel_err   (b_sel_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    a_in_data   = 16'h1234;
    a_in_sel    = 2'd0;
    a_in_valid  = 1'b1;
    a_out_ready = 4'b0000;
    b_in_data   = 16'h5678;
    b_in_sel    = 2'd1;
    b_in_valid  = 1'b1;
    b_out_ready = 3'b000;

    // Reset held two cycles with valid words offered
    step();
    check("rst_valid", 64'(a_out_valid), 64'h0);
    check("rst_data", a_out_data, 64'h0);
    check("rst_selerr", 64'(a_sel_err), 64'h0);
    step();
    reset      = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    step();
    check("post_rst_valid", 64'(a_out_valid), 64'h0);
    check("post_rst_data", a_out_data, 64'h0);
    check("post_rst_selerr", 64'(a_sel_err), 64'h0);
    check("post_rst_b_valid", 64'(b_out_valid), 64'h0);

    // Basic route to channel 2
    a_in_data  = 16'hA5C3;
    a_in_sel   = 2'd2;
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    check("route_valid", 64'(a_out_valid), 64'h4);
    check("route_data2", 64'(a_out_data[32 +: 16]), 64'hA5C3);
    a_out_ready = 4'b0100;
    step();
    a_out_ready = 4'b0000;
    check("drain_valid", 64'(a_out_valid), 64'h0);
    check("drain_keep_data2", 64'(a_out_data[32 +: 16]), 64'hA5C3);

    // Backpressure on channel 1 only
    a_in_data  = 16'h1111;
    a_in_sel   = 2'd1;
    a_in_valid = 1'b1;
    step();
    a_in_data = 16'h2222;
    #1;
    check("bp_ready_ch1", 64'(a_in_ready), 64'h0);
    step();
    check("bp_hold_valid", 64'(a_out_valid), 64'h2);
    check("bp_hold_data1", 64'(a_out_data[16 +: 16]), 64'h1111);
    a_in_data = 16'h3333;
    a_in_sel  = 2'd3;
    #1;
    check("bp_ready_ch3", 64'(a_in_ready), 64'h1);
    step();
    a_in_valid = 1'b0;
    check("bp_land_valid", 64'(a_out_valid), 64'hA);
    check("bp_land_data3", 64'(a_out_data[48 +: 16]), 64'h3333);
    check("bp_keep_data1", 64'(a_out_data[16 +: 16]), 64'h1111);
    a_out_ready = 4'b1111;
    step();
    a_out_ready = 4'b0000;
    check("drain_all_valid", 64'(a_out_valid), 64'h0);

    // Back-to-back streaming through channel 0
    a_out_ready = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      a_in_data  = 16'(i);
      a_in_sel   = 2'd0;
      a_in_valid = 1'b1;
      #1;
      check("stream_ready", 64'(a_in_ready), 64'h1);
      step();
      check("stream_valid0", 64'(a_out_valid[0]), 64'h1);
      check("stream_data0", 64'(a_out_data[15:0]), 64'(i));
    end
    a_in_valid = 1'b0;
    step();
    check("stream_end_valid", 64'(a_out_valid), 64'h0);
    check("stream_end_data0", 64'(a_out_data[15:0]), 64'h8);
`ifdef DMUX16_COUNT_EN
    check("count_after_stream", a_out_count, {16'd1, 16'd1, 16'd1, 16'd8});
`endif

    // Out-of-range select on the 3-way instance
    b_in_data  = 16'hBEEF;
    b_in_sel   = 2'd2;
    b_in_valid = 1'b1;
    step();
    b_in_data = 16'hFFFF;
    b_in_sel  = 2'd3;
    #1;
    check("bad_sel_ready", 64'(b_in_ready), 64'h1);
    step();
    b_in_valid = 1'b0;
    check("bad_sel_err", 64'(b_sel_err), 64'h1);
    check("bad_sel_valid", 64'(b_out_valid), 64'h4);
    step();
    check("bad_sel_err_clr", 64'(b_sel_err), 64'h0);
    check("bad_sel_valid2", 64'(b_out_valid), 64'h4);
    check("bad_sel_data", b_out_data, {16'hBEEF, 16'h0000, 16'h0000});

    // Reset mid-stream discards the held word and the concurrent accept
    a_in_data  = 16'h7777;
    a_in_sel   = 2'd0;
    a_in_valid = 1'b1;
    a_out_ready = 4'b0000;
    step();
    a_in_data = 16'h8888;
    a_in_sel  = 2'd1;
    reset     = 1'b1;
    step();
    check("midrst_valid", 64'(a_out_valid), 64'h0);
    check("midrst_data", a_out_data, 64'h0);
`ifdef DMUX16_COUNT_EN
    check("midrst_count", a_out_count, 64'h0);
`endif
    reset = 1'b0;

`ifdef DMUX16_COUNT_EN
    // Stream through channel 0 to bring counter 0 to 16'hFFFE, then cross the wrap
    a_in_sel    = 2'd0;
    a_in_data   = 16'h0042;
    a_in_valid  = 1'b1;
    a_out_ready = 4'b0001;
    repeat (65535) @(posedge clk);
    #1;
    check("cnt_fffe", 64'(a_out_count[15:0]), 64'hFFFE);
    step();
    check("cnt_ffff", 64'(a_out_count[15:0]), 64'hFFFF);
    step();
    check("cnt_wrap", 64'(a_out_count[15:0]), 64'h0000);
    a_in_valid = 1'b0;
    step();
    check("cnt_0001", 64'(a_out_count[15:0]), 64'h0001);
    check("cnt_others", 64'(a_out_count[63:16]), 64'h0);
    a_out_ready = 4'b0000;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
